// File: rtl/chan_550_packet_fir_coef_loader.sv
// Settles the software b2/b3 coefficient word and hands it to the channelizer FIR atomically.
// Define FIR_COEF_LOADER_SYNC_EN to hold settled words until the next frame-sync pulse.
module chan_550_packet_fir_coef_loader #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned COUNT_WIDTH   = 8
) (
    input  logic                   user_clk,
    input  logic                   user_rst,
    input  logic [31:0]            reg_data_in,
    input  logic                   sync_in,
    output logic [15:0]            coef_b2,
    output logic [15:0]            coef_b3,
    output logic                   coef_update,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] update_count
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);

`ifdef FIR_COEF_LOADER_SYNC_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, PENDING = 2'd2} state_e;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1} state_e;
    logic unused_sync_in;
    assign unused_sync_in = sync_in;
`endif

    state_e                   state_q;
    logic [WORD_W-1:0]        reg_q;
    logic [WORD_W-1:0]        active_q;
    logic [WORD_W-1:0]        cand_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     coef_update_q;
    logic                     busy_q;
    logic [COUNT_WIDTH-1:0]   update_count_q;

    // Only the registered copy of the software word is ever examined, so a write
    // landing mid-cycle cannot split across the compare and the capture.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q        <= IDLE;
            reg_q          <= '0;
            active_q       <= '0;
            cand_q         <= '0;
            cnt_q          <= '0;
            coef_update_q  <= 1'b0;
            busy_q         <= 1'b0;
            update_count_q <= '0;
        end else begin
            reg_q         <= reg_data_in;
            coef_update_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (reg_q != active_q) begin
                        cand_q  <= reg_q;
                        cnt_q   <= CNT_W'(1);
                        state_q <= SETTLE;
                        busy_q  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (reg_q != cand_q) begin
                        cand_q <= reg_q;
                        cnt_q  <= CNT_W'(1);
                    end else if (cnt_q == SETTLE_LAST) begin
`ifdef FIR_COEF_LOADER_SYNC_EN
                        state_q <= PENDING;
`else
                        active_q       <= cand_q;
                        coef_update_q  <= 1'b1;
                        update_count_q <= update_count_q + COUNT_WIDTH'(1);
                        busy_q         <= 1'b0;
                        state_q        <= IDLE;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`ifdef FIR_COEF_LOADER_SYNC_EN
                // A word change outranks a coincident sync: restart settling.
                PENDING: begin
                    if (reg_q != cand_q) begin
                        cand_q  <= reg_q;
                        cnt_q   <= CNT_W'(1);
                        state_q <= SETTLE;
                    end else if (sync_in) begin
                        active_q       <= cand_q;
                        coef_update_q  <= 1'b1;
                        update_count_q <= update_count_q + COUNT_WIDTH'(1);
                        busy_q         <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign coef_b2      = active_q[31:16];
    assign coef_b3      = active_q[15:0];
    assign coef_update  = coef_update_q;
    assign busy         = busy_q;
    assign update_count = update_count_q;

endmodule

// File: tb/tb_chan_550_packet_fir_coef_loader.sv
// Directed bench for chan_550_packet_fir_coef_loader (S=4); follows FIR_COEF_LOADER_SYNC_EN if defined.
module tb_chan_550_packet_fir_coef_loader;
    localparam int unsigned S  = 4;
    localparam int unsigned CW = 8;

    logic          user_clk = 1'b0;
    logic          user_rst;
    logic [31:0]   reg_data_in;
    logic          sync_in;
    logic [15:0]   coef_b2;
    logic [15:0]   coef_b3;
    logic          coef_update;
    logic          busy;
    logic [CW-1:0] update_count;

    int unsigned   n_chk  = 0;
    int unsigned   n_pass = 0;
    logic [31:0]   active_w = 32'h0;
    logic [CW-1:0] exp_cnt  = '0;

    always #5 user_clk = ~user_clk;

    chan_550_packet_fir_coef_loader #(
        .SETTLE_CYCLES(S),
        .COUNT_WIDTH  (CW)
    ) dut (
        .user_clk    (user_clk),
        .user_rst    (user_rst),
        .reg_data_in (reg_data_in),
        .sync_in     (sync_in),
        .coef_b2     (coef_b2),
        .coef_b3     (coef_b3),
        .coef_update (coef_update),
        .busy        (busy),
        .update_count(update_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge user_clk);
        #1;
    endtask

    // Busy, no pulse, coefficients still at the old active word.
    task automatic chk_settling(input string tag);
        chk({tag, "_flags"}, 32'({busy, coef_update}), 32'b10);
        chk({tag, "_coef"}, {coef_b2, coef_b3}, active_w);
    endtask

    // Called one edge before a no-sync build would apply the candidate.
    task automatic finish_apply(input logic [31:0] w);
        exp_cnt = exp_cnt + CW'(1);
`ifdef FIR_COEF_LOADER_SYNC_EN
        step();
        chk_settling("pending");
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
`else
        step();
`endif
        chk("apply_coef", {coef_b2, coef_b3}, w);
        chk("apply_flags", 32'({busy, coef_update}), 32'b01);
        chk("apply_count", 32'(update_count), 32'(exp_cnt));
        active_w = w;
        step();
        chk("pulse_single", 32'(coef_update), 32'h0);
    endtask

    task automatic expect_apply(input logic [31:0] w);
        reg_data_in = w;
        step();
        chk("detect_busy", 32'(busy), 32'h0);
        for (int i = 2; i <= int'(S) + 1; i++) begin
            step();
            chk_settling("settle");
        end
        finish_apply(w);
    endtask

    initial begin
        user_rst    = 1'b1;
        reg_data_in = 32'h0;
        sync_in     = 1'b0;
        repeat (3) step();
        chk("rst_b2", 32'(coef_b2), 32'h0);
        chk("rst_b3", 32'(coef_b3), 32'h0);
        chk("rst_flags", 32'({busy, coef_update}), 32'h0);
        chk("rst_count", 32'(update_count), 32'h0);
        user_rst = 1'b0;

        // Zero word matches the reset active value: nothing should happen.
        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle_quiet", {busy, coef_update, coef_b2, coef_b3}, 32'h0);
        end

        expect_apply(32'h1234_5678);

        // Restart: second write lands while the first is still settling.
        reg_data_in = 32'h0001_0002;
        step();
        chk("restart_detect", 32'(busy), 32'h0);
        repeat (2) begin
            step();
            chk_settling("restart_a");
        end
        reg_data_in = 32'h0003_0004;
        repeat (5) begin
            step();
            chk_settling("restart_b");
        end
        finish_apply(32'h0003_0004);

        // Word returns to the active value mid-settle: still applied and counted.
        reg_data_in = 32'hAAAA_5555;
        step();
        step();
        chk_settling("return_a");
        reg_data_in = 32'h0003_0004;
        repeat (5) begin
            step();
            chk_settling("return_b");
        end
        finish_apply(32'h0003_0004);

        expect_apply(32'h7FFF_8000);
        chk("neg_b2", 32'(coef_b2), 32'h0000_7FFF);
        chk("neg_b3", 32'(coef_b3), 32'h0000_8000);

`ifdef FIR_COEF_LOADER_SYNC_EN
        // Reach PENDING with 0x55556666, then change the word as sync arrives.
        reg_data_in = 32'h5555_6666;
        repeat (S + 2) step();
        chk_settling("pend_reached");
        reg_data_in = 32'h1111_2222;
        step();
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        chk_settling("sync_vs_change");
        step();
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        chk_settling("sync_in_settle");
        step();
        chk_settling("sync_in_settle2");
        finish_apply(32'h1111_2222);
`endif

        // Drive update_count through its wrap.
        for (int i = 0; i < 300 && exp_cnt != '0; i++) begin
            expect_apply(32'h0100_0000 + 32'(i));
        end
        chk("count_wrap", 32'(update_count), 32'h0);

        // Reset while settling discards the candidate; word is then re-detected.
        reg_data_in = 32'h0F0F_0F0F;
        repeat (3) step();
        chk_settling("pre_rst");
        user_rst = 1'b1;
        step();
        chk("midrst_coef", {coef_b2, coef_b3}, 32'h0);
        chk("midrst_flags", 32'({busy, coef_update}), 32'h0);
        chk("midrst_count", 32'(update_count), 32'h0);
        user_rst = 1'b0;
        active_w = 32'h0;
        exp_cnt  = '0;
        expect_apply(32'h0F0F_0F0F);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
